// File: rtl/fpu_addsub.sv
// rtl/fpu_addsub.sv - Multi-cycle IEEE-754 single-precision add/subtract stage.
// Aligns, adds, normalises one bit per cycle and rounds; non-finite classes bypass the datapath.
module fpu_addsub #(
  parameter int EXPONENT_WIDTH    = 8,
  parameter int FRACTION_WIDTH    = 23,
  parameter int SIGNIFICAND_WIDTH = 24,
  parameter int OPERAND_WIDTH     = 32
) (
  input  logic                         fpu_clk,
  input  logic                         fpu_rst_n,
  input  logic                         fpu_addsub_en_i,
  input  logic                         fpu_dec_ready_i,
  input  logic [6:0]                   fpu_op_i,
  input  logic [4:0]                   fpu_res_type_i,
  input  logic [2:0]                   fpu_round_mode_i,
  input  logic                         fpu_dec_sign1_i,
  input  logic                         fpu_dec_sign2_i,
  input  logic [EXPONENT_WIDTH-1:0]    fpu_dec_exp1_i,
  input  logic [EXPONENT_WIDTH-1:0]    fpu_dec_exp2_i,
  input  logic [SIGNIFICAND_WIDTH-1:0] fpu_dec_sfgnd1_i,
  input  logic [SIGNIFICAND_WIDTH-1:0] fpu_dec_sfgnd2_i,
  input  logic [OPERAND_WIDTH-1:0]     fpu_res_nan_i,
  output logic [OPERAND_WIDTH-1:0]     fpu_addsub_res_o,
  output logic                         fpu_addsub_valid_o,
  output logic                         fpu_addsub_busy_o,
  output logic [3:0]                   fpu_addsub_flags_o
);

  localparam int EW    = EXPONENT_WIDTH;
  localparam int FW    = FRACTION_WIDTH;
  localparam int SW    = SIGNIFICAND_WIDTH;
  localparam int EXT_W = SW + 3;
  localparam int SUM_W = EXT_W + 1;
  localparam int XW    = EW + 2;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  localparam logic [OPERAND_WIDTH-1:0] INF_POS   = {1'b0, {EW{1'b1}}, {FW{1'b0}}};
  localparam logic [OPERAND_WIDTH-1:0] MAX_FIN   = {1'b0, {(EW-1){1'b1}}, 1'b0, {FW{1'b1}}};
  localparam logic [OPERAND_WIDTH-1:0] NAN_INDET = {1'b0, {EW{1'b1}}, 1'b1, {(FW-1){1'b0}}};
  localparam logic [XW-1:0]            X_EXP_INF = XW'((1 << EW) - 1);
  localparam logic [EW-1:0]            D_MAX     = EW'(EXT_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SPECIAL, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t r_state, w_state_n;

  logic                     r_sign1, r_sign2, r_sign, r_sub;
  logic [EW-1:0]            r_exp1, r_exp2;
  logic [SW-1:0]            r_sf1, r_sf2;
  logic [2:0]               r_rm;
  logic [4:1]               r_rt;
  logic [OPERAND_WIDTH-1:0] r_nan;
  logic [XW-1:0]            r_exp;
  logic [EXT_W-1:0]         r_ma, r_mb;
  logic [SUM_W-1:0]         r_man;
  logic [OPERAND_WIDTH-1:0] r_res;
  logic [3:0]               r_flags;
  logic                     r_valid;

  logic w_unused_op;
  assign w_unused_op = ^{fpu_op_i[6:4], fpu_op_i[1:0]};

  // Alignment: subnormals use exponent 1; A is the operand with larger magnitude.
  logic [EW-1:0]    w_e1, w_e2, w_ea, w_eb, w_d;
  logic [SW-1:0]    w_sfa, w_sfb;
  logic             w_swap, w_sign_a, w_b_lost;
  logic [EXT_W-1:0] w_b_ext, w_b_sh, w_b_al;

  assign w_e1     = (r_exp1 == '0) ? EW'(1) : r_exp1;
  assign w_e2     = (r_exp2 == '0) ? EW'(1) : r_exp2;
  assign w_swap   = {w_e2, r_sf2} > {w_e1, r_sf1};
  assign w_ea     = w_swap ? w_e2 : w_e1;
  assign w_eb     = w_swap ? w_e1 : w_e2;
  assign w_sfa    = w_swap ? r_sf2 : r_sf1;
  assign w_sfb    = w_swap ? r_sf1 : r_sf2;
  assign w_sign_a = w_swap ? r_sign2 : r_sign1;
  assign w_d      = w_ea - w_eb;
  assign w_b_ext  = {w_sfb, 3'b000};
  assign w_b_sh   = w_b_ext >> w_d;
  assign w_b_lost = |(w_b_ext & ~({EXT_W{1'b1}} << w_d));
  assign w_b_al   = (w_d >= D_MAX) ? {{(EXT_W-1){1'b0}}, |w_b_ext}
                                   : {w_b_sh[EXT_W-1:1], w_b_sh[0] | w_b_lost};

  logic [SUM_W-1:0] w_sum;
  assign w_sum = r_sub ? ({1'b0, r_ma} - {1'b0, r_mb}) : ({1'b0, r_ma} + {1'b0, r_mb});

  logic w_zero_sign;
  assign w_zero_sign = r_sub ? (r_rm == RM_RDN) : r_sign;

  // Normalisation finishes on the same cycle the last left shift lands.
  logic [SUM_W-1:0] w_norm_man;
  logic [XW-1:0]    w_norm_exp;
  logic             w_norm_done;

  always_comb begin
    w_norm_man  = r_man;
    w_norm_exp  = r_exp;
    w_norm_done = 1'b1;
    if (r_man[SUM_W-1]) begin
      w_norm_man = {1'b0, r_man[SUM_W-1:2], r_man[1] | r_man[0]};
      w_norm_exp = r_exp + XW'(1);
    end else if (!r_man[SUM_W-2] && (r_exp > XW'(1))) begin
      w_norm_man  = {r_man[SUM_W-2:0], 1'b0};
      w_norm_exp  = r_exp - XW'(1);
      w_norm_done = r_man[SUM_W-3] || (r_exp <= XW'(2));
    end
  end

  logic [SW-1:0]    w_mant, w_mant_f;
  logic [SW:0]      w_mant_inc;
  logic             w_g, w_r, w_s, w_inexact, w_inc, w_ovf, w_use_inf;
  logic [XW-1:0]    w_exp_f;
  logic [EW-1:0]    w_exp_field;

  assign w_mant     = r_man[SUM_W-2:3];
  assign w_g        = r_man[2];
  assign w_r        = r_man[1];
  assign w_s        = r_man[0];
  assign w_inexact  = w_g | w_r | w_s;
  assign w_mant_inc = {1'b0, w_mant} + {{SW{1'b0}}, w_inc};
  assign w_mant_f   = w_mant_inc[SW] ? w_mant_inc[SW:1] : w_mant_inc[SW-1:0];
  assign w_exp_f    = r_exp + XW'(w_mant_inc[SW]);
  assign w_ovf      = w_exp_f >= X_EXP_INF;
  assign w_exp_field = w_mant_f[SW-1] ? w_exp_f[EW-1:0] : '0;

  always_comb begin
    w_inc     = 1'b0;
    w_use_inf = 1'b1;
    case (r_rm)
      RM_RTZ: begin w_inc = 1'b0;                 w_use_inf = 1'b0;    end
      RM_RDN: begin w_inc = r_sign & w_inexact;   w_use_inf = r_sign;  end
      RM_RUP: begin w_inc = ~r_sign & w_inexact;  w_use_inf = ~r_sign; end
      RM_RMM: begin w_inc = w_g;                  w_use_inf = 1'b1;    end
      default: begin w_inc = w_g & (w_r | w_s | w_mant[0]); w_use_inf = 1'b1; end
    endcase
  end

  logic [OPERAND_WIDTH-1:0] w_res_n;
  logic [3:0]               w_flags_n;

  always_comb begin
    w_res_n   = r_res;
    w_flags_n = r_flags;
    case (r_state)
      S_SPECIAL: begin
        w_flags_n = 4'b0000;
        if (r_rt[4])      w_res_n = r_nan;
        else if (r_rt[3]) w_res_n = INF_POS;
        else if (r_rt[2]) w_res_n = INF_POS | {1'b1, {(OPERAND_WIDTH-1){1'b0}}};
        else begin
          w_res_n   = NAN_INDET;
          w_flags_n = 4'b1000;
        end
      end
      S_ADD: begin
        w_res_n   = {w_zero_sign, {(OPERAND_WIDTH-1){1'b0}}};
        w_flags_n = 4'b0000;
      end
      S_ROUND: begin
        if (w_ovf) begin
          w_res_n   = {r_sign, w_use_inf ? INF_POS[OPERAND_WIDTH-2:0] : MAX_FIN[OPERAND_WIDTH-2:0]};
          w_flags_n = 4'b0101;
        end else begin
          w_res_n   = {r_sign, w_exp_field, w_mant_f[FW-1:0]};
          w_flags_n = {2'b00, ~w_mant_f[SW-1] & w_inexact, w_inexact};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:
        if (fpu_addsub_en_i && fpu_dec_ready_i && (fpu_op_i[2] || fpu_op_i[3]))
          w_state_n = fpu_res_type_i[0] ? S_ALIGN : S_SPECIAL;
      S_SPECIAL: w_state_n = S_DONE;
      S_ALIGN:   w_state_n = S_ADD;
      S_ADD:     w_state_n = (w_sum == '0) ? S_DONE : S_NORM;
      S_NORM:    w_state_n = w_norm_done ? S_ROUND : S_NORM;
      S_ROUND:   w_state_n = S_DONE;
      S_DONE:    w_state_n = S_IDLE;
      default:   w_state_n = S_IDLE;
    endcase
    if ((r_state != S_IDLE) && !fpu_addsub_en_i)
      w_state_n = S_IDLE;
  end

  always_ff @(posedge fpu_clk or negedge fpu_rst_n) begin
    if (!fpu_rst_n) r_state <= S_IDLE;
    else            r_state <= w_state_n;
  end

  always_ff @(posedge fpu_clk or negedge fpu_rst_n) begin
    if (!fpu_rst_n) begin
      r_sign1 <= 1'b0;  r_sign2 <= 1'b0;  r_sign <= 1'b0;  r_sub <= 1'b0;
      r_exp1  <= '0;    r_exp2  <= '0;    r_sf1  <= '0;    r_sf2 <= '0;
      r_rm    <= RM_RNE; r_rt   <= '0;    r_nan  <= '0;
      r_exp   <= '0;    r_ma    <= '0;    r_mb   <= '0;    r_man <= '0;
      r_res   <= '0;    r_flags <= '0;    r_valid <= 1'b0;
    end else begin
      r_valid <= (w_state_n == S_DONE);
      if (w_state_n == S_DONE) begin
        r_res   <= w_res_n;
        r_flags <= w_flags_n;
      end
      case (r_state)
        S_IDLE: if (w_state_n != S_IDLE) begin
          r_sign1 <= fpu_dec_sign1_i;
          r_sign2 <= fpu_dec_sign2_i ^ fpu_op_i[3];
          r_exp1  <= fpu_dec_exp1_i;
          r_exp2  <= fpu_dec_exp2_i;
          r_sf1   <= fpu_dec_sfgnd1_i;
          r_sf2   <= fpu_dec_sfgnd2_i;
          r_rm    <= (fpu_round_mode_i > RM_RMM) ? RM_RNE : fpu_round_mode_i;
          r_rt    <= fpu_res_type_i[4:1];
          r_nan   <= fpu_res_nan_i;
        end
        S_ALIGN: begin
          r_sign <= w_sign_a;
          r_sub  <= r_sign1 ^ r_sign2;
          r_exp  <= {2'b00, w_ea};
          r_ma   <= {w_sfa, 3'b000};
          r_mb   <= w_b_al;
        end
        S_ADD:  r_man <= w_sum;
        S_NORM: begin
          r_man <= w_norm_man;
          r_exp <= w_norm_exp;
        end
        default: ;
      endcase
    end
  end

  assign fpu_addsub_res_o   = r_res;
  assign fpu_addsub_flags_o = r_flags;
  assign fpu_addsub_valid_o = r_valid;
  assign fpu_addsub_busy_o  = (r_state != S_IDLE);

endmodule

// File: tb/tb_fpu_addsub.sv
// tb/tb_fpu_addsub.sv - Directed self-checking bench for fpu_addsub.
module tb_fpu_addsub;

  localparam logic [6:0] OP_ADD = 7'b0000100;
  localparam logic [6:0] OP_SUB = 7'b0001000;
  localparam logic [4:0] RT_FIN = 5'b00001;
  localparam logic [4:0] RT_NINF = 5'b00100;
  localparam logic [4:0] RT_INDET = 5'b00010;
  localparam logic [4:0] RT_NAN = 5'b10000;

  logic        fpu_clk = 1'b0;
  logic        fpu_rst_n = 1'b0;
  logic        en = 1'b0;
  logic        rdy = 1'b0;
  logic [6:0]  op_i = '0;
  logic [4:0]  rt_i = RT_FIN;
  logic [2:0]  rm_i = '0;
  logic        s1 = 1'b0, s2 = 1'b0;
  logic [7:0]  e1 = '0, e2 = '0;
  logic [23:0] f1 = '0, f2 = '0;
  logic [31:0] nan_i = 32'h7FC12345;
  logic [31:0] res_o;
  logic        valid_o, busy_o;
  logic [3:0]  flags_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] g_res;
  logic [3:0]  g_fl;
  int          g_lat, g_nv;

  fpu_addsub dut (
    .fpu_clk(fpu_clk), .fpu_rst_n(fpu_rst_n), .fpu_addsub_en_i(en),
    .fpu_dec_ready_i(rdy), .fpu_op_i(op_i), .fpu_res_type_i(rt_i),
    .fpu_round_mode_i(rm_i), .fpu_dec_sign1_i(s1), .fpu_dec_sign2_i(s2),
    .fpu_dec_exp1_i(e1), .fpu_dec_exp2_i(e2), .fpu_dec_sfgnd1_i(f1),
    .fpu_dec_sfgnd2_i(f2), .fpu_res_nan_i(nan_i), .fpu_addsub_res_o(res_o),
    .fpu_addsub_valid_o(valid_o), .fpu_addsub_busy_o(busy_o),
    .fpu_addsub_flags_o(flags_o)
  );

  always #5 fpu_clk = ~fpu_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] rt, input logic [2:0] rm,
                       input logic [31:0] a, input logic [31:0] b);
    op_i = op; rt_i = rt; rm_i = rm;
    s1 = a[31]; e1 = a[30:23]; f1 = {|a[30:23], a[22:0]};
    s2 = b[31]; e2 = b[30:23]; f2 = {|b[30:23], b[22:0]};
  endtask

  // Latency counts clock edges from the capture edge (edge 1) to the edge that raises valid.
  task automatic run_op(input logic [6:0] op, input logic [4:0] rt, input logic [2:0] rm,
                        input logic [31:0] a, input logic [31:0] b);
    @(negedge fpu_clk);
    drive(op, rt, rm, a, b);
    rdy = 1'b1;
    g_nv = 0; g_lat = 0; g_res = 'x; g_fl = 'x;
    for (int i = 1; i <= 40; i++) begin
      @(posedge fpu_clk); #1;
      rdy = 1'b0;
      if (valid_o) begin
        g_nv++;
        if (g_nv == 1) begin
          g_lat = i; g_res = res_o; g_fl = flags_o;
        end
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge fpu_clk);
    chk("reset_res", res_o, 32'h0);
    chk("reset_flags", {28'd0, flags_o}, 32'h0);
    chk("reset_valid", {31'd0, valid_o}, 32'h0);
    chk("reset_busy", {31'd0, busy_o}, 32'h0);
    fpu_rst_n = 1'b1;
    en = 1'b1;

    run_op(OP_ADD, RT_FIN, 3'd0, 32'h3F800000, 32'h3F800000);
    chk("one_plus_one_res", g_res, 32'h40000000);
    chk("one_plus_one_flags", {28'd0, g_fl}, 32'h0);
    chk("one_plus_one_pulses", g_nv, 1);
    chk("one_plus_one_lat", g_lat, 5);

    run_op(OP_SUB, RT_FIN, 3'd0, 32'h40400000, 32'h3F800000);
    chk("three_minus_one_res", g_res, 32'h40000000);
    chk("three_minus_one_lat", g_lat, 5);

    run_op(OP_SUB, RT_FIN, 3'd0, 32'h3F800000, 32'h3F800000);
    chk("zero_rne_res", g_res, 32'h00000000);
    run_op(OP_SUB, RT_FIN, 3'd2, 32'h3F800000, 32'h3F800000);
    chk("zero_rdn_res", g_res, 32'h80000000);
    chk("zero_rdn_flags", {28'd0, g_fl}, 32'h0);

    run_op(OP_ADD, RT_FIN, 3'd0, 32'h3F800000, 32'h33800000);
    chk("tie_rne_res", g_res, 32'h3F800000);
    chk("tie_rne_flags", {28'd0, g_fl}, 32'h1);
    run_op(OP_ADD, RT_FIN, 3'd3, 32'h3F800000, 32'h33800000);
    chk("tie_rup_res", g_res, 32'h3F800001);
    run_op(OP_ADD, RT_FIN, 3'd7, 32'h3F800000, 32'h33800000);
    chk("tie_mode7_res", g_res, 32'h3F800000);

    run_op(OP_ADD, RT_FIN, 3'd0, 32'h7F7FFFFF, 32'h7F7FFFFF);
    chk("ovf_rne_res", g_res, 32'h7F800000);
    chk("ovf_rne_flags", {28'd0, g_fl}, 32'h5);
    run_op(OP_ADD, RT_FIN, 3'd1, 32'h7F7FFFFF, 32'h7F7FFFFF);
    chk("ovf_rtz_res", g_res, 32'h7F7FFFFF);
    chk("ovf_rtz_flags", {28'd0, g_fl}, 32'h5);

    run_op(OP_ADD, RT_INDET, 3'd0, 32'h0, 32'h0);
    chk("indet_res", g_res, 32'h7FC00000);
    chk("indet_flags", {28'd0, g_fl}, 32'h8);
    chk("indet_lat", g_lat, 2);
    run_op(OP_SUB, RT_NAN, 3'd0, 32'h0, 32'h0);
    chk("nan_res", g_res, 32'h7FC12345);
    run_op(OP_ADD, RT_NINF, 3'd0, 32'h0, 32'h0);
    chk("neg_inf_res", g_res, 32'hFF800000);

    run_op(OP_SUB, RT_FIN, 3'd0, 32'h00000003, 32'h00000001);
    chk("subnormal_sub_res", g_res, 32'h00000002);
    chk("subnormal_sub_flags", {28'd0, g_fl}, 32'h0);

    // 23 normalisation shifts land exactly on the smallest normal.
    run_op(OP_SUB, RT_FIN, 3'd0, 32'h0C000001, 32'h0C000000);
    chk("long_norm_res", g_res, 32'h00800000);
    chk("long_norm_lat", g_lat, 27);

    // Abort in the middle of a long normalisation.
    @(negedge fpu_clk);
    drive(OP_SUB, RT_FIN, 3'd0, 32'h0C000001, 32'h0C000000);
    rdy = 1'b1;
    @(posedge fpu_clk); #1;
    rdy = 1'b0;
    repeat (5) @(posedge fpu_clk);
    #1;
    chk("abort_busy_before", {31'd0, busy_o}, 32'h1);
    @(negedge fpu_clk);
    en = 1'b0;
    @(posedge fpu_clk); #1;
    chk("abort_busy_after", {31'd0, busy_o}, 32'h0);
    g_nv = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge fpu_clk); #1;
      if (valid_o) g_nv++;
    end
    chk("abort_no_valid", g_nv, 0);
    chk("abort_res_held", res_o, 32'h00800000);
    en = 1'b1;

    // A ready pulse while busy must not start a second operation.
    @(negedge fpu_clk);
    drive(OP_ADD, RT_FIN, 3'd0, 32'h3F800000, 32'h3F800000);
    rdy = 1'b1;
    @(posedge fpu_clk); #1;
    rdy = 1'b0;
    @(negedge fpu_clk);
    drive(OP_ADD, RT_INDET, 3'd0, 32'h0, 32'h0);
    rdy = 1'b1;
    @(negedge fpu_clk);
    rdy = 1'b0;
    g_nv = 0; g_res = 'x;
    for (int i = 0; i < 40; i++) begin
      @(posedge fpu_clk); #1;
      if (valid_o) begin
        g_nv++;
        g_res = res_o;
      end
    end
    chk("busy_ignore_pulses", g_nv, 1);
    chk("busy_ignore_res", g_res, 32'h40000000);

    // Asynchronous reset mid-operation clears outputs at once.
    @(negedge fpu_clk);
    drive(OP_ADD, RT_FIN, 3'd0, 32'h3F800000, 32'h3F800000);
    rdy = 1'b1;
    @(posedge fpu_clk); #1;
    rdy = 1'b0;
    @(posedge fpu_clk); #1;
    fpu_rst_n = 1'b0;
    #1;
    chk("midreset_busy", {31'd0, busy_o}, 32'h0);
    chk("midreset_res", res_o, 32'h0);
    @(negedge fpu_clk);
    fpu_rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
